// File: rtl/l1_mem_responder_pkg.sv
// ============================================================================
// Module      : l1_mem_responder_pkg
// Description : Shared constants for the L1 data-cache memory responder:
//               line/word geometry, FSM state encodings, MMIO window and the
//               poison word returned on an MMIO timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package l1_mem_responder_pkg;

  // Geometry shared with the L1 dcache
  localparam int WORD_W           = 32;
  localparam int DEF_LINE_WORDS   = 8;
  localparam int DEF_LINE_W       = DEF_LINE_WORDS * WORD_W;

  // Cycles an MMIO access may wait for mmio_ack before it is force-completed
  localparam int DEF_MMIO_TIMEOUT = 255;

  // Read data handed back when an MMIO device never answers
  localparam logic [WORD_W-1:0] MMIO_POISON = 32'hDEADBEEF;

  // Uncached window: every address whose top nibble is 0xF
  localparam logic [WORD_W-1:0] MMIO_BASE = 32'hF000_0000;
  localparam logic [WORD_W-1:0] MMIO_MASK = 32'hF000_0000;

  // Responder FSM encodings
  localparam int         ST_W       = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LINE_RD = 3'd1;
  localparam logic [2:0] ST_LINE_WR = 3'd2;
  localparam logic [2:0] ST_MMIO    = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

endpackage : l1_mem_responder_pkg

`default_nettype wire

// File: rtl/mmio_addr.sv
// ============================================================================
// Module      : mmio_addr
// Description : Address classifier shared by the L1 path: flags a byte
//               address as belonging to the uncached MMIO window.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmio_addr
  import l1_mem_responder_pkg::*;
(
  input  logic [WORD_W-1:0] addr,
  output logic              is_mmio
);

  // Masked compare keeps the window definition entirely in the package
  assign is_mmio = ((addr & MMIO_MASK) == MMIO_BASE);

endmodule : mmio_addr

`default_nettype wire

// File: rtl/l1_mem_responder.sv
// ============================================================================
// Module      : l1_mem_responder
// Description : Memory-side responder for L1 dcache misses and flushes.
//               Line fills and writebacks are split into word beats on the
//               memory port; MMIO words go out as one access on the MMIO port
//               with a timeout. Every request ends with a one-cycle done.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module l1_mem_responder
  import l1_mem_responder_pkg::*;
#(
  parameter int LINE_WORDS   = DEF_LINE_WORDS,
  parameter int MMIO_TIMEOUT = DEF_MMIO_TIMEOUT
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  // L1 dcache side
  input  logic                         l1_mmu_req_read,
  input  logic                         l1_mmu_req_write,
  input  logic [WORD_W-1:0]            l1_mmu_req_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] l1_mmu_write_data,
  output logic                         mmu_l1_done,
  output logic [LINE_WORDS*WORD_W-1:0] mmu_l1_read_data,
  // word memory port
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  input  logic [WORD_W-1:0]            mem_rdata,
  // MMIO port
  output logic                         mmio_req,
  output logic                         mmio_we,
  output logic [WORD_W-1:0]            mmio_addr,
  output logic [WORD_W-1:0]            mmio_wdata,
  input  logic                         mmio_ack,
  input  logic [WORD_W-1:0]            mmio_rdata
);

  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int TMO_W  = $clog2(MMIO_TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MMIO_TIMEOUT - 1);

  logic [ST_W-1:0]   r_state;
  logic [WORD_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_we;
  logic [BEAT_W-1:0] r_beat;
  logic [TMO_W-1:0]  r_tmo;
  logic [LINE_W-1:0] r_rdata;

  logic              w_is_mmio;
  logic              w_req;
  logic              w_tmo_hit;

  // Classify the incoming address; only consulted while IDLE
  mmio_addr u_mmio_addr (
    .addr    (l1_mmu_req_addr),
    .is_mmio (w_is_mmio)
  );

  assign w_req     = l1_mmu_req_read | l1_mmu_req_write;
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // Downstream strobes are pure state decodes, so reset drops them on the same edge
  assign mem_req     = (r_state == ST_LINE_RD) || (r_state == ST_LINE_WR);
  assign mem_we      = (r_state == ST_LINE_WR);
  assign mem_addr    = {r_addr[WORD_W-1:BEAT_W+2], r_beat, 2'b00};
  assign mem_wdata   = r_wdata[r_beat*WORD_W +: WORD_W];
  assign mmio_req    = (r_state == ST_MMIO);
  assign mmio_we     = (r_state == ST_MMIO) && r_we;
  assign mmio_addr   = r_addr;
  assign mmio_wdata  = r_wdata[WORD_W-1:0];
  assign mmu_l1_done = (r_state == ST_RESP);
  assign mmu_l1_read_data = r_rdata;

  // Request sequencing: accept in IDLE, step beats on mem_ack, wait/time out on MMIO
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_beat  <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= l1_mmu_req_addr;
            r_wdata <= l1_mmu_write_data;
            r_we    <= l1_mmu_req_write;
            r_beat  <= '0;
            r_tmo   <= '0;
            if (w_is_mmio)            r_state <= ST_MMIO;
            else if (l1_mmu_req_write) r_state <= ST_LINE_WR;
            else                      r_state <= ST_LINE_RD;
          end
        end
        ST_LINE_RD, ST_LINE_WR: begin
          if (mem_ack) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) r_state <= ST_RESP;
          end
        end
        ST_MMIO: begin
          // A real ack wins over a timeout landing in the same cycle
          if (mmio_ack || w_tmo_hit) r_state <= ST_RESP;
          else                       r_tmo   <= r_tmo + 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Fill line: written only by read beats and MMIO read completion, so writes leave it intact
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if ((r_state == ST_LINE_RD) && mem_ack) begin
      r_rdata[r_beat*WORD_W +: WORD_W] <= mem_rdata;
    end else if ((r_state == ST_MMIO) && !r_we) begin
      if (mmio_ack)       r_rdata <= {{(LINE_W-WORD_W){1'b0}}, mmio_rdata};
      else if (w_tmo_hit) r_rdata <= {{(LINE_W-WORD_W){1'b0}}, MMIO_POISON};
    end
  end

endmodule : l1_mem_responder

`default_nettype wire

// File: tb/tb_l1_mem_responder.sv
// ============================================================================
// Module      : tb_l1_mem_responder
// Description : Self-checking bench for l1_mem_responder. Models memory and
//               MMIO devices with random latencies and compares every beat,
//               MMIO access, completion and returned line against expectations
//               built from the transaction itself.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_l1_mem_responder;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         l1_mmu_req_read, l1_mmu_req_write;
  logic [31:0]  l1_mmu_req_addr;
  logic [255:0] l1_mmu_write_data;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mmio_req, mmio_we, mmio_ack;
  logic [31:0]  mmio_addr, mmio_wdata, mmio_rdata;

  l1_mem_responder dut (
    .sys_clk (sys_clk), .rst_n (rst_n),
    .l1_mmu_req_read (l1_mmu_req_read), .l1_mmu_req_write (l1_mmu_req_write),
    .l1_mmu_req_addr (l1_mmu_req_addr), .l1_mmu_write_data (l1_mmu_write_data),
    .mmu_l1_done (mmu_l1_done), .mmu_l1_read_data (mmu_l1_read_data),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_ack (mem_ack), .mem_rdata (mem_rdata),
    .mmio_req (mmio_req), .mmio_we (mmio_we), .mmio_addr (mmio_addr), .mmio_wdata (mmio_wdata),
    .mmio_ack (mmio_ack), .mmio_rdata (mmio_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Device behaviour knobs
  int          gap_min = 0, gap_max = 0, mmio_dly_min = 0, mmio_dly_max = 0;
  bit          mmio_noack = 0, force_ack = 0, rd_hash = 0;
  logic [31:0] seed = 32'h0, mmio_val = 32'h0;
  logic [255:0] exp_rdata = '0;

  // Logs of what the devices accepted
  logic [31:0] beat_addr_q[$], beat_data_q[$];
  bit          beat_we_q[$];
  logic [31:0] mio_addr_q[$], mio_data_q[$];
  bit          mio_we_q[$];

  int done_cnt = 0, mem_req_cyc = 0, mmio_req_cyc = 0, overlap_cnt = 0;

  // Backing memory contents: beat index, or an address hash for random runs
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] b;
    b = a >> 2;
    return rd_hash ? ((a * 32'h9E3779B1) ^ seed) : {29'd0, b[2:0]};
  endfunction

  // Memory device: acks after a random number of idle cycles, logs each accepted beat
  initial begin : mem_side
    int wait_left;
    wait_left = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge sys_clk); #2;
      if (force_ack) begin
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      end else if (mem_req) begin
        if (wait_left > 0) begin
          mem_ack = 1'b0; mem_rdata = $urandom; wait_left--;
        end else begin
          mem_ack = 1'b1; mem_rdata = mem_word(mem_addr);
          beat_addr_q.push_back(mem_addr);
          beat_data_q.push_back(mem_wdata);
          beat_we_q.push_back(mem_we);
          wait_left = $urandom_range(gap_max, gap_min);
        end
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
        wait_left = $urandom_range(gap_max, gap_min);
      end
    end
  end

  // MMIO device: one ack per access after a random delay, or never when mmio_noack
  initial begin : mmio_side
    int dly;
    bit pending;
    dly = 0; pending = 0;
    mmio_ack = 1'b0; mmio_rdata = '0;
    forever begin
      @(posedge sys_clk); #2;
      if (mmio_req && !mmio_noack) begin
        if (!pending) begin dly = $urandom_range(mmio_dly_max, mmio_dly_min); pending = 1; end
        if (dly == 0) begin
          mmio_ack = 1'b1; mmio_rdata = mmio_val; pending = 0;
          mio_addr_q.push_back(mmio_addr);
          mio_data_q.push_back(mmio_wdata);
          mio_we_q.push_back(mmio_we);
        end else begin
          mmio_ack = 1'b0; mmio_rdata = $urandom; dly--;
        end
      end else begin
        mmio_ack = 1'b0; mmio_rdata = $urandom; pending = 0;
      end
    end
  end

  // Per-cycle activity counters
  always @(posedge sys_clk) begin
    #3;
    if (mmu_l1_done === 1'b1) done_cnt++;
    if (mem_req === 1'b1) mem_req_cyc++;
    if (mmio_req === 1'b1) mmio_req_cyc++;
    if (mem_req === 1'b1 && mmio_req === 1'b1) overlap_cnt++;
  end

  // Hard stop in case the run wedges somewhere unbounded
  initial begin : watchdog
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Issue one request, scramble L1 inputs while busy, return cycles until done is sampled
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] line, output int lat);
    int n;
    l1_mmu_req_read = rd; l1_mmu_req_write = wr;
    l1_mmu_req_addr = addr; l1_mmu_write_data = line;
    @(posedge sys_clk); #1;
    n = 0;
    while (mmu_l1_done !== 1'b1) begin
      if (n >= 600) begin
        chk("done_wait_expired", 1'b0, 1'b1);
        break;
      end
      l1_mmu_req_read = 1'($urandom); l1_mmu_req_write = 1'($urandom);
      l1_mmu_req_addr = $urandom;
      for (int w = 0; w < 8; w++) l1_mmu_write_data[w*32 +: 32] = $urandom;
      @(posedge sys_clk); #1;
      n++;
    end
    lat = n + 1;
    l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
    chk("read_data_at_done", mmu_l1_read_data, exp_rdata);
    @(posedge sys_clk); #1;
    chk("done_single_pulse", mmu_l1_done, 1'b0);
  endtask

  // Run one transaction and check it against the expected device traffic
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, input int exp_lat);
    bit is_m;
    int d0, m0, mr0, lat;
    logic [31:0] ba;
    is_m = (addr[31:28] == 4'hF);
    if (!wr && !is_m)
      for (int i = 0; i < 8; i++) exp_rdata[i*32 +: 32] = mem_word({addr[31:5], 3'(i), 2'b00});
    else if (!wr && is_m)
      exp_rdata = {224'd0, (mmio_noack ? 32'hDEADBEEF : mmio_val)};
    beat_addr_q.delete(); beat_data_q.delete(); beat_we_q.delete();
    mio_addr_q.delete(); mio_data_q.delete(); mio_we_q.delete();
    d0 = done_cnt; m0 = mem_req_cyc; mr0 = mmio_req_cyc;
    do_req(rd, wr, addr, line, lat);
    chk("done_count", done_cnt - d0, 1);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    if (!is_m) begin
      chk("beat_count", beat_addr_q.size(), 8);
      chk("mmio_idle_on_line", mio_addr_q.size(), 0);
      for (int i = 0; i < 8 && i < beat_addr_q.size(); i++) begin
        ba = {addr[31:5], 3'(i), 2'b00};
        chk("beat_addr", beat_addr_q[i], ba);
        chk("beat_we", beat_we_q[i], wr);
        if (wr) chk("beat_wdata", beat_data_q[i], line[i*32 +: 32]);
      end
    end else begin
      chk("mem_idle_on_mmio", mem_req_cyc - m0, 0);
      chk("mmio_count", mio_addr_q.size(), mmio_noack ? 0 : 1);
      if (mio_addr_q.size() > 0) begin
        chk("mmio_addr", mio_addr_q[0], addr);
        chk("mmio_we", mio_we_q[0], wr);
        if (wr) chk("mmio_wdata", mio_data_q[0], line[31:0]);
      end
      if (mmio_noack) chk("timeout_req_cycles", mmio_req_cyc - mr0, 255);
    end
    chk("read_data_after", mmu_l1_read_data, exp_rdata);
  endtask

  initial begin : main
    logic [255:0] line;
    logic [31:0]  addr;
    logic [255:0] prev;
    int kind;
    bit rd, wr, is_m;

    rst_n = 1'b0;
    l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
    l1_mmu_req_addr = '0; l1_mmu_write_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_done", mmu_l1_done, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mmio_req", mmio_req, 1'b0);
    chk("rst_mmio_we", mmio_we, 1'b0);
    chk("rst_read_data", mmu_l1_read_data, '0);
    chk("rst_mem_addr", mem_addr, '0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Fill, memory acks every cycle, rdata = beat index
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 9);

    // Writeback with two idle cycles between beats
    gap_min = 2; gap_max = 2;
    for (int w = 0; w < 8; w++) line[w*32 +: 32] = 32'hA0 + w;
    run_txn(1'b0, 1'b1, 32'h0000_8040, line, -1);

    // Flush then fill back to back
    gap_min = 0; gap_max = 0; rd_hash = 1; seed = 32'h1357_2468;
    for (int w = 0; w < 8; w++) line[w*32 +: 32] = $urandom;
    run_txn(1'b0, 1'b1, 32'h0000_2000, line, 9);
    run_txn(1'b1, 1'b0, 32'h0000_4460, '0, 9);

    // MMIO read with same-cycle ack, then MMIO write
    mmio_dly_min = 0; mmio_dly_max = 0; mmio_val = 32'h0000_005A;
    run_txn(1'b1, 1'b0, 32'hF000_0010, '0, 2);
    line = {224'h0, 32'hC0FF_EE01};
    run_txn(1'b0, 1'b1, 32'hF000_0020, line, 2);

    // MMIO read that is never acknowledged
    mmio_noack = 1;
    run_txn(1'b1, 1'b0, 32'hF000_0030, '0, 256);
    mmio_noack = 0;

    // Reset in the middle of a fill after four beats
    prev = exp_rdata;
    l1_mmu_req_read = 1'b1; l1_mmu_req_addr = 32'h0000_3000;
    @(posedge sys_clk); #1;
    l1_mmu_req_read = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("partial_word3", mmu_l1_read_data[3*32 +: 32], mem_word(32'h0000_300C));
    chk("partial_word4", mmu_l1_read_data[4*32 +: 32], prev[4*32 +: 32]);
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_read_data", mmu_l1_read_data, '0);
    force_ack = 1;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk); #1;
      chk("late_ack_mem_req", mem_req, 1'b0);
      chk("late_ack_done", mmu_l1_done, 1'b0);
    end
    force_ack = 0;
    exp_rdata = '0;
    @(posedge sys_clk); #1;
    run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 9);

    // Randomized mix of fills, writebacks, read+write and MMIO accesses
    seed = $urandom;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(2, 0);
      rd = (kind != 1);
      wr = (kind != 0);
      is_m = ($urandom_range(3, 0) == 0);
      addr = $urandom & 32'h0FFF_FFFF;
      if (is_m) addr = addr | 32'hF000_0000;
      for (int w = 0; w < 8; w++) line[w*32 +: 32] = $urandom;
      gap_min = 0; gap_max = $urandom_range(3, 0);
      mmio_dly_min = 0; mmio_dly_max = $urandom_range(4, 0);
      mmio_val = $urandom;
      run_txn(rd, wr, addr, line, -1);
    end

    chk("port_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_l1_mem_responder

`default_nettype wire
